// File: rtl/spu_sequencer_pkg.sv
// spu_sequencer_pkg: shared SPU constants, FSM state enum and queued command layout.
package spu_sequencer_pkg;
    localparam logic [15:0] SPU_BASE = 16'hFF10;
    localparam logic [5:0]  MAX_OFF  = 6'h2F;
    localparam logic [5:0]  OFF_NR52 = 6'h16;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, ISSUE} state_t;
    typedef struct packed {
        logic [7:0] delay;
        logic [5:0] rg;
        logic [7:0] data;
    } cmd_t;
endpackage

// File: rtl/spu_sequencer_if.sv
// spu_sequencer_if: CPU request, command push and arbitrated SPU bus signals.
// master drives cpu_* and cmd_* and observes cmd_ready and spu_*; slave is the sequencer side.
interface spu_sequencer_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_read;
    logic        cpu_write;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_delay;
    logic [5:0]  cmd_reg;
    logic [7:0]  cmd_data;
    logic [15:0] spu_addr;
    logic [7:0]  spu_data;
    logic        spu_read;
    logic        spu_write;
    modport master (
        output cpu_addr, cpu_data, cpu_read, cpu_write, cmd_valid, cmd_delay, cmd_reg, cmd_data,
        input  cmd_ready, spu_addr, spu_data, spu_read, spu_write
    );
    modport slave (
        input  cpu_addr, cpu_data, cpu_read, cpu_write, cmd_valid, cmd_delay, cmd_reg, cmd_data,
        output cmd_ready, spu_addr, spu_data, spu_read, spu_write
    );
endinterface

// File: rtl/spu_cmd_fifo.sv
// spu_cmd_fifo: DEPTH-entry command FIFO with flush.
// Ports: i_push/i_pop/i_flush control, i_din pushed entry, o_dout head entry,
// o_count occupancy, o_full/o_empty status. Push while full and pop while empty are ignored.
module spu_cmd_fifo
    import spu_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  cmd_t       i_din,
    output cmd_t       o_dout,
    output logic [4:0] o_count,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);
    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [4:0]    r_count;
    logic          w_push;
    logic          w_pop;
    assign o_full  = r_count == 5'(DEPTH);
    assign o_empty = r_count == 5'd0;
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + 5'(w_push) - 5'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wp] <= i_din;
    end
endmodule

// File: rtl/spu_sequencer.sv
// spu_sequencer: queues delayed SPU register writes and arbitrates them behind CPU accesses.
// Ports: clk/rst; i_tphase T-phase index (divider advances on 2); i_flush discards queue and
// pending command; bus (slave) carries cpu_*, cmd_* and the arbitrated spu_* port;
// o_busy queue non-empty or sequencer active; o_count occupancy; o_err sticky illegal-command flag.
module spu_sequencer
    import spu_sequencer_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_tphase,
    input  logic              i_flush,
    spu_sequencer_if.slave    bus,
    output logic              o_busy,
    output logic [4:0]        o_count,
    output logic              o_err
);
    localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
    state_t        r_state;
    cmd_t          r_cmd;
    logic [7:0]    r_rem;
    logic [DW-1:0] r_div;
    logic          r_err;
    logic          w_cpu_req;
    logic          w_tick;
    logic          w_issue;
    logic          w_pwr_off;
    logic          w_flush_all;
    logic          w_full;
    logic          w_empty;
    cmd_t          w_head;
    assign w_cpu_req   = bus.cpu_read || bus.cpu_write;
    assign w_tick      = i_tphase == 8'd2 && r_div == DIV_MAX;
    // The queued write goes out only when the CPU leaves the bus and no flush cancels it.
    assign w_issue     = r_state == ISSUE && !w_cpu_req && !i_flush;
    // Powering the SPU off via FF26 bit 7 = 0 makes every queued command meaningless.
    assign w_pwr_off   = w_issue && r_cmd.rg == OFF_NR52 && !r_cmd.data[7];
    assign w_flush_all = i_flush || w_pwr_off;
    assign bus.cmd_ready = !w_full && !w_flush_all;
    assign bus.spu_read  = bus.cpu_read;
    assign bus.spu_write = w_cpu_req ? bus.cpu_write : w_issue;
    assign bus.spu_addr  = w_cpu_req ? bus.cpu_addr : w_issue ? SPU_BASE + {10'd0, r_cmd.rg} : 16'd0;
    assign bus.spu_data  = w_cpu_req ? bus.cpu_data : w_issue ? r_cmd.data : 8'd0;
    assign o_busy = !w_empty || r_state != IDLE;
    assign o_err  = r_err;
    spu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.cmd_valid && bus.cmd_ready),
        .i_pop   (r_state == LOAD),
        .i_flush (w_flush_all),
        .i_din   (cmd_t'({bus.cmd_delay, bus.cmd_reg, bus.cmd_data})),
        .o_dout  (w_head),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cmd   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (i_tphase == 8'd2) r_div <= r_div == DIV_MAX ? '0 : r_div + 1'b1;
            if (i_flush) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: if (!w_empty) r_state <= LOAD;
                    LOAD: begin
                        r_cmd <= w_head;
                        r_rem <= w_head.delay;
                        if (w_head.rg > MAX_OFF) begin
                            r_err   <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_state <= w_head.delay == 8'd0 ? ISSUE : WAIT;
                        end
                    end
                    WAIT: if (w_tick) begin
                        r_rem <= r_rem - 8'd1;
                        if (r_rem == 8'd1) r_state <= ISSUE;
                    end
                    ISSUE: if (!w_cpu_req) r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/spu_sequencer.md
SPU_SEQUENCER -- requirements
Module: spu_sequencer

Interface
REQ-001 Parameter: DEPTH, default 8, command FIFO entries (power of two, 2..16).
REQ-002 Parameter: TICK_DIV, default 8192, tphase==2 cycles per sequencer tick.
REQ-003 clk  in  1  clock; reset rst, synchronous, active-high.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 tphase  in  8  T-phase index; the block advances the tick divider only when tphase==2.
REQ-006 cpu_addr/cpu_data/cpu_read/cpu_write  in  16/8/1/1  CPU bus request toward the SPU.
REQ-007 cmd_valid  in  1; cmd_ready  out  1; cmd_delay  in  8 (ticks); cmd_reg  in  6 (offset from FF10); cmd_data  in  8.
REQ-008 flush  in  1  single-cycle pulse that discards the queue and any pending command.
REQ-009 spu_addr/spu_data/spu_read/spu_write  out  16/8/1/1  arbitrated SPU bus port.
REQ-010 busy  out  1  FIFO non-empty or state != IDLE; count  out  5  FIFO occupancy.
REQ-011 err  out  1  sticky flag, set by a dropped illegal command.

Function
REQ-012 CPU priority: the block SHALL pass the cpu_* signals combinationally to spu_* in any cycle where cpu_read or cpu_write is high.
REQ-013 Push: cmd_valid && cmd_ready SHALL store {delay, reg, data}; cmd_ready = (count < DEPTH).
REQ-014 Simultaneous push and pop SHALL leave count unchanged; a push while full SHALL be ignored.
REQ-015 Tick divider: counts tphase==2 cycles from 0 to TICK_DIV-1 and wraps; the tick pulse is high for 1 cycle at the wrap.
REQ-016 FSM states: IDLE, LOAD, WAIT, ISSUE.
REQ-017 IDLE -> LOAD when FIFO non-empty; LOAD pops the head into holding registers in 1 cycle.
REQ-018 LOAD -> ISSUE if delay==0, else -> WAIT with remaining = delay.
REQ-019 WAIT: remaining decrements on each tick; the block SHALL enter ISSUE in the cycle after the tick that brings remaining to 0.
REQ-020 ISSUE: in the first cycle without a CPU request, drive spu_write=1, spu_addr=16'hFF10+reg, spu_data=data for exactly 1 cycle, then -> IDLE.
REQ-021 ISSUE stalls indefinitely while the CPU holds the bus; the write SHALL NOT be lost or duplicated.
REQ-022 Illegal reg (offset > 6'h2F, i.e. above FF3F) SHALL be dropped in LOAD, SHALL set err, and the FSM SHALL return to IDLE.
REQ-023 Issuing a write to FF26 with data[7]=0 SHALL also flush the FIFO in the same cycle (power-off cancels the queue).
REQ-024 flush: FIFO emptied and FSM -> IDLE next cycle; if the CPU is idle, no spu_write SHALL occur in the flush cycle; cmd_ready is low during the flush cycle.
REQ-025 When no requester is active: spu_* = 0 (read=0, write=0, addr=0, data=0).
REQ-026 spu_read SHALL originate only from the CPU; the sequencer issues writes only.
REQ-027 err clears only on rst.

Reset
REQ-028 On rst: FIFO empty, count=0, FSM=IDLE, divider=0, remaining=0, err=0, cmd_ready=1, busy=0, spu_* outputs 0 unless the CPU is driving.
REQ-029 rst asserted mid-WAIT or mid-ISSUE SHALL abandon the command without issuing a write.

Structure
REQ-030 The shared types package SHALL hold the SPU base address 16'hFF10, the max offset 6'h2F, the FF26 offset, and the FSM state enum.
REQ-031 The FIFO SHALL be one sub-module, spu_cmd_fifo (DEPTH parameter; push/pop/flush; count, full, empty outputs).

Verification (bench uses TICK_DIV=4)
REQ-032 Push {delay 0, reg 02, data F3} while idle -> spu_write with addr FF12, data F3, exactly 1 cycle, 2 cycles after the push.
REQ-033 Push {delay 3, reg 04, data 87} -> write to FF14 issued after the 3rd tick (12 tphase==2 cycles); busy high throughout.
REQ-034 Hold cpu_write to FF24 for 5 cycles during ISSUE -> CPU write forwarded each cycle; sequencer write occurs on the 6th cycle, exactly once.
REQ-035 Push 9 commands with DEPTH=8 and no pops -> cmd_ready=0 at count=8; the 9th command is ignored; count stays 8.
REQ-036 Push reg 30 -> no spu_write; err=1 and stays 1; the following legal command issues normally.
REQ-037 Queue {0,16,00} then {0,02,F0} -> write to FF26 with data 00, then the FIFO is empty and no write to FF12 occurs; the flush pulse mid-WAIT likewise yields no write.
